// File: rtl/ps2_digit_decoder_if.sv
// Scan-code input and digit output stream of the PS/2 digit decoder.
// The decoder takes the master view; the producer/consumer environment takes the slave view.
interface ps2_digit_decoder_if;
    logic [7:0] CodeData;
    logic       CodeValid;
    logic [3:0] DigitData;
    logic       DigitValid;
    logic       DigitReady;

    modport master (
        input  CodeData,
        input  CodeValid,
        input  DigitReady,
        output DigitData,
        output DigitValid
    );

    modport slave (
        output CodeData,
        output CodeValid,
        output DigitReady,
        input  DigitData,
        input  DigitValid
    );
endinterface

// File: rtl/ps2_digit_decoder.sv
// Decodes PS/2 set-2 scan codes into decimal digits, queues them in a small FIFO
// and keeps the last four digits as BCD on led.
//
// state     | meaning
// IDLE      | waiting for a make code or a prefix byte
// BREAK     | 0xF0 seen; the next byte is a release and is discarded
// EXT       | 0xE0 seen; extended key, make is discarded
// EXT_BREAK | 0xE0 0xF0 seen; the next byte is discarded
module ps2_digit_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 SysClock,
    input  logic                 ResetN,
    ps2_digit_decoder_if.master  link,
    output logic [15:0]          led,
    output logic                 Overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    state_t        state_q, state_d;
    logic          is_digit;
    logic [3:0]    digit;
    logic          emit;
    logic          clear_led;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push, drop;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (link.CodeData)
            8'h45, 8'h70: digit = 4'd0;
            8'h16, 8'h69: digit = 4'd1;
            8'h1E, 8'h72: digit = 4'd2;
            8'h26, 8'h7A: digit = 4'd3;
            8'h25, 8'h6B: digit = 4'd4;
            8'h2E, 8'h73: digit = 4'd5;
            8'h36, 8'h74: digit = 4'd6;
            8'h3D, 8'h6C: digit = 4'd7;
            8'h3E, 8'h75: digit = 4'd8;
            8'h46, 8'h7D: digit = 4'd9;
            default:      is_digit = 1'b0;
        endcase
    end

    always_ff @(posedge SysClock or negedge ResetN) begin
        if (!ResetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        clear_led = 1'b0;
        if (link.CodeValid) begin
            case (state_q)
                IDLE: begin
                    if (link.CodeData == 8'hF0)      state_d = BREAK;
                    else if (link.CodeData == 8'hE0) state_d = EXT;
                    else if (is_digit)               emit = 1'b1;
                    else if (link.CodeData == 8'h66) clear_led = 1'b1;
                end
                BREAK:     if (link.CodeData != 8'hF0) state_d = IDLE;
                EXT: begin
                    if (link.CodeData == 8'hF0)      state_d = EXT_BREAK;
                    else if (link.CodeData != 8'hE0) state_d = IDLE;
                end
                EXT_BREAK: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // A push into a full FIFO still succeeds when the head leaves on the same edge.
    assign full            = (count == DEPTH_C);
    assign link.DigitValid = (count != '0);
    assign link.DigitData  = mem[rd_ptr];
    assign pop             = link.DigitValid & link.DigitReady;
    assign push            = emit & (~full | pop);
    assign drop            = emit & full & ~pop;

    always_ff @(posedge SysClock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= digit;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge SysClock or negedge ResetN) begin
        if (!ResetN) begin
            led      <= 16'h0000;
            Overflow <= 1'b0;
        end else begin
            if (emit)           led <= {led[11:0], digit};
            else if (clear_led) led <= 16'h0000;
            if (drop) Overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_digit_decoder.sv
// Scoreboard bench for ps2_digit_decoder: directed scenarios plus random scan-code traffic
// checked against a prefix/occupancy reference model.
module tb_ps2_digit_decoder;
    localparam int DEPTH = 4;

    logic        SysClock = 1'b0;
    logic        ResetN   = 1'b0;
    logic [15:0] led;
    logic        Overflow;

    ps2_digit_decoder_if link();

    ps2_digit_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .SysClock (SysClock),
        .ResetN   (ResetN),
        .link     (link.master),
        .led      (led),
        .Overflow (Overflow)
    );

    always #5 SysClock = ~SysClock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          occ      = 0;
    logic        m_brk    = 1'b0;
    logic        m_ext    = 1'b0;
    logic [15:0] m_led    = 16'h0000;
    logic        m_ovf    = 1'b0;
    int          sb_q[$];
    logic [7:0]  codes [20] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 20; i++) if (codes[i] == b) return i % 10;
        return -1;
    endfunction

    // Reference: prefix flags plus an occupancy count; accepted digits go to the scoreboard.
    task automatic model_edge(input logic cv, input logic [7:0] cd, input logic rdy);
        int d;
        d = -1;
        if (cv) begin
            if (!m_ext && !m_brk) begin
                if (cd == 8'hF0)      m_brk = 1'b1;
                else if (cd == 8'hE0) m_ext = 1'b1;
                else begin
                    d = lookup(cd);
                    if (d < 0 && cd == 8'h66) m_led = 16'h0000;
                end
            end else if (m_brk && !m_ext) begin
                m_brk = (cd == 8'hF0);
            end else if (m_ext && !m_brk) begin
                if (cd == 8'hF0)      m_brk = 1'b1;
                else if (cd != 8'hE0) m_ext = 1'b0;
            end else begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        if (rdy && occ > 0) occ--;
        if (d >= 0) begin
            m_led = {m_led[11:0], 4'(d)};
            if (occ < DEPTH) begin
                occ++;
                sb_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic cv, input logic [7:0] cd, input logic rdy);
        link.CodeValid  = cv;
        link.CodeData   = cd;
        link.DigitReady = rdy;
        @(posedge SysClock);
        #2;
        if (ResetN) model_edge(cv, cd, rdy);
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        cycle(1'b1, b, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        ResetN          = 1'b0;
        link.CodeValid  = 1'b0;
        link.DigitReady = 1'b0;
        occ   = 0;
        m_brk = 1'b0;
        m_ext = 1'b0;
        m_led = 16'h0000;
        m_ovf = 1'b0;
        sb_q.delete();
        @(posedge SysClock); #2;
        @(posedge SysClock); #2;
        ResetN = 1'b1;
    endtask

    // Monitor: compares outputs every cycle and pops the scoreboard on each handshake.
    always @(negedge SysClock) begin
        if (!ResetN) begin
            check("rst_valid", link.DigitValid, 0);
            check("rst_data", link.DigitData, 0);
            check("rst_led", led, 0);
            check("rst_ovf", Overflow, 0);
        end else begin
            check("valid", link.DigitValid, occ != 0);
            check("led", led, m_led);
            check("ovf", Overflow, m_ovf);
            if (link.DigitValid && link.DigitReady) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL digit: got %0h with nothing expected at %0t", link.DigitData, $time);
                end else begin
                    int e;
                    e = sb_q.pop_front();
                    check("digit", link.DigitData, e);
                end
            end
        end
    end

    initial begin
        logic [15:0] saved_led;
        link.CodeValid  = 1'b0;
        link.CodeData   = 8'h00;
        link.DigitReady = 1'b0;
        ResetN = 1'b0;
        repeat (2) @(posedge SysClock);
        #2;
        ResetN = 1'b1;

        // make / break of key 1
        send(8'h16, 0); send(8'hF0, 0); send(8'h16, 0); idle(1, 0);
        check("r029_led", led, 16'h0001);
        check("r029_valid", link.DigitValid, 1);
        idle(3, 1);

        // overflow with a stalled consumer
        do_reset();
        send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0); send(8'h2E, 0); send(8'h36, 0); idle(1, 0);
        check("r030_led", led, 16'h3456);
        check("r030_ovf", Overflow, 1);
        idle(6, 1);

        // push and pop together on a full FIFO
        do_reset();
        send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0);
        send(8'h45, 1); idle(1, 0);
        check("r031_ovf", Overflow, 0);
        check("r031_valid", link.DigitValid, 1);
        idle(6, 1);

        // extended keys are ignored
        saved_led = led;
        send(8'hE0, 1); send(8'h70, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h70, 1); idle(1, 1);
        check("r032_led", led, saved_led);
        check("r032_empty", link.DigitValid, 0);
        send(8'h70, 1); idle(2, 1);

        // clear key
        send(8'h3E, 0); send(8'h46, 0); send(8'h66, 0); idle(1, 0);
        check("r033_led", led, 16'h0000);
        idle(4, 1);

        // reset in the middle of a break sequence
        send(8'hF0, 0);
        do_reset();
        send(8'h16, 0);
        check("r034_valid", link.DigitValid, 1);
        idle(3, 1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic       cv, rdy;
            logic [7:0] b;
            int         r;
            cv  = ($urandom % 3) != 0;
            rdy = (n % 400 < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            r   = $urandom % 8;
            if (r < 4)       b = codes[$urandom % 20];
            else if (r == 4) b = 8'hF0;
            else if (r == 5) b = 8'hE0;
            else if (r == 6) b = 8'h66;
            else             b = 8'($urandom);
            if (($urandom % 700) == 0) do_reset();
            cycle(cv, b, rdy);
        end
        idle(DEPTH + 3, 1);
        check("drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_digit_decoder.md
PS2_DIGIT_DECODER -- requirements
Module: ps2_digit_decoder

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 4, number of digit entries in the output FIFO (power of two, 2..16).
REQ-002 SysClock  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 ResetN  in  1  reset; asynchronous, active-low.
REQ-004 CodeData  in  8  scan-code byte from the upstream PS/2 frame receiver, already synchronous to SysClock.
REQ-005 CodeValid  in  1  one-cycle strobe qualifying CodeData; the block SHALL accept every strobe, with no back-pressure upstream.
REQ-006 DigitData  out  4  digit (0-9) at the FIFO head.
REQ-007 DigitValid  out  1  high while the FIFO is non-empty.
REQ-008 DigitReady  in  1  consumer accepts DigitData when DigitValid and DigitReady are both high at a rising edge.
REQ-009 led  out  16  last four accepted digits as BCD nibbles; newest in led[3:0].
REQ-010 Overflow  out  1  sticky flag: a digit was dropped because the FIFO was full.

Function
REQ-011 Prefix FSM states SHALL be IDLE, BREAK, EXT and EXT_BREAK, advancing only on cycles where CodeValid=1.
REQ-012 IDLE transitions:
- 0xF0 -> BREAK
- 0xE0 -> EXT
- digit make code -> emit digit, stay in IDLE
- 0x66 -> clear led to 0x0000, stay in IDLE
- any other byte -> IDLE, no action
REQ-013 BREAK: 0xF0 stays in BREAK; any other byte returns to IDLE with no emit.
REQ-014 EXT: 0xF0 -> EXT_BREAK; 0xE0 stays in EXT; any other byte returns to IDLE with no emit (extended keys are ignored).
REQ-015 EXT_BREAK: any byte returns to IDLE with no emit.
REQ-016 Digit make codes SHALL map as follows:
- main row 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> 0-9
- keypad 0x70,0x69,0x72,0x7A,0x6B,0x73,0x74,0x6C,0x75,0x7D -> 0-9
REQ-017 Typematic repeat makes SHALL each emit a digit; there is no repeat suppression.
REQ-018 An emit SHALL shift led left by 4 and insert the digit at [3:0] on the same edge that consumes the byte, independent of FIFO fullness.
REQ-019 An emit SHALL push the digit into the FIFO; when the FIFO starts empty, DigitValid SHALL rise on the cycle after the CodeValid edge (latency 1).
REQ-020 A pop SHALL occur on an edge where DigitValid=1 and DigitReady=1; the next entry, or DigitValid=0, SHALL appear on the following cycle.
REQ-021 A push while full with no pop in the same cycle SHALL drop the digit, leave FIFO contents unchanged and set Overflow.
REQ-022 A push and a pop on the same edge SHALL both take effect, including when the FIFO is full (no drop, no Overflow) and when it holds one entry.
REQ-023 When the FIFO is empty, DigitReady SHALL be ignored and the pointers SHALL NOT move.
REQ-024 The read and write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits wide and SHALL never exceed FIFO_DEPTH.
REQ-025 DigitData SHALL come directly from the FIFO storage head with no extra register stage; its value SHALL be don't-care while DigitValid=0.
REQ-026 Overflow SHALL be cleared only by reset.

Reset
REQ-027 While ResetN=0, the block SHALL hold the following values:
- FSM = IDLE
- FIFO empty, pointers = 0
- DigitValid = 0
- led = 0x0000
- Overflow = 0
- DigitData = 0
REQ-028 Reset asserted mid-sequence (for example in BREAK, or with a FIFO that is not empty) SHALL discard all state immediately; the first byte after release SHALL be decoded from IDLE.

Verification
REQ-029 Bytes 0x16, 0xF0, 0x16 -> exactly one digit 1 emitted, led=0x0001, FSM back in IDLE.
REQ-030 Bytes 0x1E,0x26,0x25,0x2E,0x36 with DigitReady=0 and FIFO_DEPTH=4 -> FIFO holds 2,3,4,5; led=0x3456; digit 6 dropped; Overflow=1.
REQ-031 FIFO full with DigitReady=1 and a new 0x45 strobe on the same edge -> one pop plus one push, no Overflow, occupancy stays 4.
REQ-032 Bytes 0xE0, 0x70, 0xE0, 0xF0, 0x70 -> no emits, led unchanged, FSM in IDLE; then 0x70 -> digit 0 emitted.
REQ-033 Bytes 0x3E, 0x46, 0x66 -> two digits in the FIFO, led=0x0000 after 0x66.
REQ-034 Sequence 0xF0, then ResetN pulsed low, then 0x16 -> digit 1 emitted, DigitValid=1 one cycle later.
